vga_timing_monitor: RTL and testbench
=====================================

# vga_timing_monitor

Receive-side companion to the VGA timing generator. Samples an incoming h_sync/v_sync/display-enable stream on a pixel strobe. Measures line length, frame height and sync widths, recovers pixel coordinates, and reports lock against expected 640x480 timing. Used in the display path as a loopback checker and as the front end for video capture.

## Interface
- H_TOTAL_EXP, 800: expected pixel strobes per line (h_sync fall to h_sync fall)
- V_TOTAL_EXP, 525: expected lines per frame (v_sync fall to v_sync fall)
- H_SYNC_EXP, 96: expected h_sync low width, in strobes
- V_SYNC_EXP, 2: expected v_sync low width, in lines
- LOCK_FRAMES, 2: consecutive clean frames required to assert lock (1..15)

Ports:
- clk  in  1  system clock; one clock, all logic on posedge clk
- rst_n  in  1  asynchronous, active-low reset
- pix_en  in  1  pixel strobe; inputs are sampled and state advances only on cycles with pix_en=1
- h_sync_in  in  1  horizontal sync, active low
- v_sync_in  in  1  vertical sync, active low
- de_in  in  1  display enable, active high
- pixel_x  out  10  count of de_in=1 samples earlier in the current line
- pixel_y  out  10  count of lines containing de_in=1 since the last v_sync fall
- h_total  out  11  last measured line length, in strobes
- v_total  out  10  last measured frame height, in lines
- locked  out  1  timing matches expectations
- frame_start  out  1  one-cycle pulse on each v_sync falling edge
- timing_err  out  1  one-cycle pulse on any mismatch while locked

## Operation
- Sample registers hs_q, vs_q, de_q load on pix_en=1. Reset value of hs_q and vs_q is 1 so that no edge is detected spuriously. Edges compare the current input with the q register.
- hcnt (11b): +1 per strobe, saturates at 2047. On an h fall: h_total <= hcnt+1, then hcnt <= 0.
- hs_w (8b): counts strobes while h_sync_in=0, saturating. On an h rise, it is compared with H_SYNC_EXP.
- vcnt (10b): +1 on each h fall, saturates at 1023. On a v fall: v_total <= vcnt (vcnt+1 if an h fall occurs in the same sample), then vcnt <= 0.
- vs_w: counts h falls while v_sync_in=0. On a v rise, it is compared with V_SYNC_EXP.
- pixel_x: +1 per strobe with de_in=1; cleared on h fall.
- pixel_y: +1 on h fall if the line just ended had any de_in=1; cleared on v fall.
- Line mismatch: on an h fall, hcnt+1 != H_TOTAL_EXP, or hcnt saturated; or on an h rise, hs_w != H_SYNC_EXP.
- Frame mismatch: on a v fall, the measured frame height != V_TOTAL_EXP; or on a v rise, vs_w != V_SYNC_EXP. Any line mismatch in a frame marks that frame bad.
- State machine:
  - SEARCH: wait for the first v fall, then clear good count and frame-bad flag, and go to MEASURE.
  - MEASURE: on each v fall, good = frame_bad ? 0 : good+1, then clear frame_bad. When good reaches LOCK_FRAMES, go to LOCKED.
  - LOCKED: any line or frame mismatch gives a timing_err pulse, locked drops, good <= 0, and state goes to MEASURE.
- The first partial frame after SEARCH is never counted as good.
- Measurement counters run in every state. h_total and v_total update on every edge regardless of lock.

## Timing
- Reset (rst_n=0, asynchronous): state=SEARCH. All outputs 0, all counters 0, hs_q=vs_q=1, de_q=0.
- All outputs are registered. They reflect a detected edge on the clk edge where pix_en=1 with that edge, and are visible the following cycle. Latency from sampled input to output is 1 clk.
- frame_start and timing_err are exactly one clk wide, even if pix_en stays high.
- With pix_en=0, nothing changes; pulses deassert.
- When h fall and v fall occur in the same sample, the line is closed first, then the frame.
- Reset mid-frame discards all measurement. Lock needs a full v fall plus LOCKED-count frames again.
- locked rises in the cycle after the v fall that completes the LOCK_FRAMES-th clean frame.

## Test plan
- Nominal generator timing (800x525, hsync 96, vsync 2, pix_en every 4th clk) from reset:
  - frame_start on each frame.
  - h_total=800, v_total=525.
  - locked=1 after the 3rd v fall (SEARCH, then 2 clean frames), with no timing_err.
- Locked stream, one line stretched to 801 strobes: timing_err pulses once at that h fall, locked=0, then relock after 2 clean frames.
- Scan check: pixel_x reaches 639 on the last active pixel of a line and is 0 after h fall. pixel_y reads 479 during the last active line and 0 after v fall.
- h_sync held low for 3000 strobes: hcnt saturates at 2047. The next h fall reports h_total=2047 and is a mismatch.
- Coincident h fall and v fall in one sample with vcnt=524: v_total=525, vcnt=0.
- Assert rst_n mid-frame while locked: outputs are 0 immediately (asynchronous). After release, no lock until 2 full clean frames after the first v fall.

Source files
------------

// File: rtl/vga_timing_monitor.sv
// VGA receive-side timing monitor: measures line/frame geometry,
// recovers pixel coordinates and tracks lock to expected timing.
module vga_timing_monitor #(
  parameter int unsigned H_TOTAL_EXP = 800,
  parameter int unsigned V_TOTAL_EXP = 525,
  parameter int unsigned H_SYNC_EXP  = 96,
  parameter int unsigned V_SYNC_EXP  = 2,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  input  logic        h_sync_in,
  input  logic        v_sync_in,
  input  logic        de_in,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic [10:0] h_total,
  output logic [9:0]  v_total,
  output logic        locked,
  output logic        frame_start,
  output logic        timing_err
);

  localparam logic [11:0] H_TOT  = 12'(H_TOTAL_EXP);
  localparam logic [9:0]  V_TOT  = 10'(V_TOTAL_EXP);
  localparam logic [7:0]  H_SW   = 8'(H_SYNC_EXP);
  localparam logic [9:0]  V_SW   = 10'(V_SYNC_EXP);
  localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    LOCKED
  } state_t;

  state_t state, state_n;

  logic        hs_q, vs_q, de_q;
  logic [10:0] hcnt;
  logic [7:0]  hs_w;
  logic [9:0]  vcnt;
  logic [9:0]  vs_w;
  logic        line_seen;
  logic [3:0]  good, good_n;
  logic        frame_bad, frame_bad_n;
  logic        err_n;

  logic        h_fall, h_rise, v_fall, v_rise;
  logic        h_sat;
  logic [11:0] h_len;
  logic [10:0] v_len;
  logic [9:0]  v_meas;
  logic        line_err, frame_err;
  logic [3:0]  good_inc;

  assign h_fall = pix_en & hs_q & ~h_sync_in;
  assign h_rise = pix_en & ~hs_q & h_sync_in;
  assign v_fall = pix_en & vs_q & ~v_sync_in;
  assign v_rise = pix_en & ~vs_q & v_sync_in;

  assign h_sat  = &hcnt;
  assign h_len  = {1'b0, hcnt} + 12'd1;
  // a coincident h fall closes its line into the frame being closed
  assign v_len  = {1'b0, vcnt} + {10'd0, h_fall};
  assign v_meas = v_len[10] ? 10'h3ff : v_len[9:0];

  assign line_err = (h_fall & (h_sat | (h_len != H_TOT)))
                  | (h_rise & (hs_w != H_SW));
  assign frame_err = (v_fall & (v_meas != V_TOT))
                   | (v_rise & (vs_w != V_SW));

  assign good_inc = good + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      de_q      <= 1'b0;
      hcnt      <= '0;
      hs_w      <= '0;
      vcnt      <= '0;
      vs_w      <= '0;
      line_seen <= 1'b0;
      h_total   <= '0;
      v_total   <= '0;
      pixel_x   <= '0;
      pixel_y   <= '0;
    end else if (pix_en) begin
      hs_q <= h_sync_in;
      vs_q <= v_sync_in;
      de_q <= de_in;

      if (h_fall) begin
        h_total <= h_sat ? 11'h7ff : h_len[10:0];
        hcnt    <= '0;
      end else if (!h_sat) begin
        hcnt <= hcnt + 11'd1;
      end

      if (h_rise) begin
        hs_w <= '0;
      end else if (!h_sync_in && !(&hs_w)) begin
        hs_w <= hs_w + 8'd1;
      end

      if (v_fall) begin
        v_total <= v_meas;
        vcnt    <= '0;
      end else if (h_fall && !(&vcnt)) begin
        vcnt <= vcnt + 10'd1;
      end

      if (v_rise) begin
        vs_w <= '0;
      end else if (h_fall && !v_sync_in && !(&vs_w)) begin
        vs_w <= vs_w + 10'd1;
      end

      // de_q holds the sample just before this strobe
      line_seen <= h_fall ? 1'b0 : (line_seen | de_q);

      if (h_fall) begin
        pixel_x <= '0;
      end else if (de_in && !(&pixel_x)) begin
        pixel_x <= pixel_x + 10'd1;
      end

      if (v_fall) begin
        pixel_y <= '0;
      end else if (h_fall && (line_seen | de_q) && !(&pixel_y)) begin
        pixel_y <= pixel_y + 10'd1;
      end
    end
  end

  always_comb begin
    state_n     = state;
    good_n      = good;
    err_n       = 1'b0;
    frame_bad_n = v_fall ? 1'b0 : (frame_bad | line_err | frame_err);
    unique case (state)
      SEARCH: begin
        if (v_fall) begin
          state_n = MEASURE;
          good_n  = '0;
        end
      end
      MEASURE: begin
        if (v_fall) begin
          if (frame_bad | line_err | frame_err) begin
            good_n = '0;
          end else begin
            good_n = good_inc;
            if (good_inc >= LOCK_N) state_n = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (line_err | frame_err) begin
          err_n   = 1'b1;
          good_n  = '0;
          state_n = MEASURE;
        end
      end
      default: state_n = SEARCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SEARCH;
      good        <= '0;
      frame_bad   <= 1'b0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      timing_err  <= 1'b0;
    end else begin
      state       <= state_n;
      good        <= good_n;
      frame_bad   <= frame_bad_n;
      locked      <= (state_n == LOCKED);
      frame_start <= v_fall;
      timing_err  <= err_n;
    end
  end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor on a scaled-down raster
// (40x12 lines, hsync 4, vsync 2, strobe every 4th clk).
module tb_vga_timing_monitor;

  localparam int HT = 40;
  localparam int HA = 32;
  localparam int HS0 = 34;
  localparam int HSW = 4;
  localparam int VT = 12;
  localparam int VA = 8;
  localparam int VS0 = 9;
  localparam int VSW = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_en = 1'b0;
  logic       h_sync_in = 1'b1;
  logic       v_sync_in = 1'b1;
  logic       de_in = 1'b0;
  logic [9:0] pixel_x, pixel_y;
  logic [10:0] h_total;
  logic [9:0] v_total;
  logic       locked, frame_start, timing_err;

  int vectors = 0;
  int miscompares = 0;
  int fs_cnt = 0;
  int err_cnt = 0;
  int err_htot = 0;

  vga_timing_monitor #(
    .H_TOTAL_EXP(HT),
    .V_TOTAL_EXP(VT),
    .H_SYNC_EXP(HSW),
    .V_SYNC_EXP(VSW),
    .LOCK_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pix_en(pix_en),
    .h_sync_in(h_sync_in),
    .v_sync_in(v_sync_in),
    .de_in(de_in),
    .pixel_x(pixel_x),
    .pixel_y(pixel_y),
    .h_total(h_total),
    .v_total(v_total),
    .locked(locked),
    .frame_start(frame_start),
    .timing_err(timing_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_start) fs_cnt++;
    if (timing_err) begin
      err_cnt++;
      err_htot = int'(h_total);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic hs, input logic vs, input logic de);
    @(negedge clk);
    h_sync_in = hs;
    v_sync_in = vs;
    de_in = de;
    pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic gen_frame(input int v0, input int v1, input int stretch,
                           input int voff, input bit scan);
    int hn, hh, pos;
    logic hs, vs, de;
    for (int v = v0; v < v1; v++) begin
      hn = (v == stretch) ? HT + 1 : HT;
      for (int h = 0; h < hn; h++) begin
        hh = (h > HT - 1) ? HT - 1 : h;
        pos = v * HT + hh;
        de = (hh < HA) && (v < VA);
        hs = !(hh >= HS0 && hh < HS0 + HSW);
        vs = !(pos >= VS0 * HT + voff && pos < (VS0 + VSW) * HT + voff);
        if (scan && v == VA - 1 && h == HA - 1) begin
          check("px_last", int'(pixel_x), HA - 1);
          check("py_last", int'(pixel_y), VA - 1);
        end
        step(hs, vs, de);
        if (scan && v == VA - 1 && h == HS0) begin
          check("px_hfall", int'(pixel_x), 0);
          check("py_end", int'(pixel_y), VA);
        end
        if (scan && v == VS0 && h == voff) begin
          check("py_vfall", int'(pixel_y), 0);
        end
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_px", int'(pixel_x), 0);
    check("rst_py", int'(pixel_y), 0);
    check("rst_ht", int'(h_total), 0);
    check("rst_vt", int'(v_total), 0);
    check("rst_lock", int'(locked), 0);
    check("rst_fs", int'(frame_start), 0);
    check("rst_err", int'(timing_err), 0);
    rst_n = 1'b1;

    gen_frame(0, VT, -1, 0, 1'b0);
    check("f0_vt", int'(v_total), VS0);
    check("f0_ht", int'(h_total), HT);
    check("f0_fs", fs_cnt, 1);
    gen_frame(0, VT, -1, 0, 1'b1);
    check("f1_lock", int'(locked), 0);
    check("f1_vt", int'(v_total), VT);
    gen_frame(0, VT, -1, 0, 1'b0);
    check("f2_lock", int'(locked), 1);
    check("f2_fs", fs_cnt, 3);
    check("f2_err", err_cnt, 0);
    check("f2_ht", int'(h_total), HT);

    gen_frame(0, VT, 4, 0, 1'b0);
    check("st_err", err_cnt, 1);
    check("st_htot", err_htot, HT + 1);
    check("st_lock", int'(locked), 0);
    check("st_vt", int'(v_total), VT);
    gen_frame(0, VT, -1, 0, 1'b0);
    check("st_relock1", int'(locked), 0);
    gen_frame(0, VT, -1, 0, 1'b0);
    check("st_relock2", int'(locked), 1);
    check("st_err2", err_cnt, 1);

    gen_frame(0, VT, -1, HS0, 1'b0);
    check("co_err", err_cnt, 2);
    check("co_vt0", int'(v_total), VT + 1);
    gen_frame(0, VT, -1, HS0, 1'b0);
    check("co_vt1", int'(v_total), VT);
    gen_frame(0, VT, -1, HS0, 1'b0);
    check("co_vt2", int'(v_total), VT);
    check("co_lock", int'(locked), 1);
    check("co_fs", fs_cnt, 9);

    gen_frame(0, 5, -1, 0, 1'b0);
    check("pre_rst_lock", int'(locked), 1);
    #3 rst_n = 1'b0;
    #1;
    check("mrst_lock", int'(locked), 0);
    check("mrst_ht", int'(h_total), 0);
    check("mrst_vt", int'(v_total), 0);
    check("mrst_px", int'(pixel_x), 0);
    @(negedge clk);
    rst_n = 1'b1;
    gen_frame(5, VT, -1, 0, 1'b0);
    check("mr_lock0", int'(locked), 0);
    gen_frame(0, VT, -1, 0, 1'b0);
    check("mr_lock1", int'(locked), 0);
    gen_frame(0, VT, -1, 0, 1'b0);
    check("mr_lock2", int'(locked), 1);
    check("mr_fs", fs_cnt, 12);
    check("mr_err", err_cnt, 2);

    for (int i = 0; i < 3000; i++) step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("sat_ht", int'(h_total), 2047);
    check("sat_lock", int'(locked), 0);
    check("sat_err", err_cnt, 3);

    @(negedge clk);
    h_sync_in = 1'b1;
    repeat (3) @(negedge clk);
    h_sync_in = 1'b0;
    repeat (3) @(negedge clk);
    check("noen_ht", int'(h_total), 2047);
    check("noen_err", int'(timing_err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
